// File: rtl/pwm_tick_gen.sv
// PWM generator driven by an external tick strobe; period/duty updates are
// double-buffered and only take effect at a period wrap or on start-up.
module pwm_tick_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pwm_out,
  output logic             cycle_done,
  output logic             pending
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] p_act, p_act_nxt, d_act, d_act_nxt;
  logic [WIDTH-1:0] p_shd, p_shd_nxt, d_shd, d_shd_nxt;
  logic             pending_nxt, pwm_nxt, done_nxt, apply;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    p_act_nxt   = p_act;
    d_act_nxt   = d_act;
    p_shd_nxt   = p_shd;
    d_shd_nxt   = d_shd;
    pending_nxt = pending;
    pwm_nxt     = 1'b0;
    done_nxt    = 1'b0;
    apply       = 1'b0;

    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          apply     = pending;
        end
      end
      RUN: begin
        if (!en) begin
          // Disable wins over a coincident wrap: no cycle_done on the way out.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          pwm_nxt = (cnt < d_act);
          if (tick) begin
            if (cnt == p_act) begin
              cnt_nxt  = '0;
              done_nxt = 1'b1;
              apply    = pending;
            end else begin
              cnt_nxt = cnt + WIDTH'(1);
            end
          end
        end
      end
    endcase

    // Apply reads the old shadow; a same-cycle load re-arms pending afterwards.
    if (apply) begin
      p_act_nxt   = p_shd;
      d_act_nxt   = d_shd;
      pending_nxt = 1'b0;
    end
    if (load) begin
      p_shd_nxt   = period_in;
      d_shd_nxt   = duty_in;
      pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      p_act      <= '0;
      d_act      <= '0;
      p_shd      <= '0;
      d_shd      <= '0;
      pending    <= 1'b0;
      pwm_out    <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      p_act      <= p_act_nxt;
      d_act      <= d_act_nxt;
      p_shd      <= p_shd_nxt;
      d_shd      <= d_shd_nxt;
      pending    <= pending_nxt;
      pwm_out    <= pwm_nxt;
      cycle_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_tick_gen.sv
// Directed bench for pwm_tick_gen; observes {pwm_out, cycle_done, pending}.
module tb_pwm_tick_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] period_in = '0;
  logic [7:0] duty_in = '0;
  logic       pwm_out, cycle_done, pending;

  int n_vec = 0;
  int n_err = 0;

  pwm_tick_gen #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .en(en), .load(load),
    .period_in(period_in), .duty_in(duty_in),
    .pwm_out(pwm_out), .cycle_done(cycle_done), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: {pwm,done,pend} got=%b expected=%b", tag, got, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step(input string tag, input logic [2:0] exp);
    @(posedge clk);
    #1;
    chk(tag, {pwm_out, cycle_done, pending}, exp);
  endtask

  task automatic load_pd(input logic [7:0] p, input logic [7:0] d, input string tag,
                         input logic [2:0] exp);
    period_in = p;
    duty_in   = d;
    load      = 1'b1;
    step(tag, exp);
    load      = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 chk("rst_async", {pwm_out, cycle_done, pending}, 3'b000);
    step("rst_hold", 3'b000);
    rst = 1'b0;

    // P=3,D=2 loaded in IDLE, tick every clk
    tick = 1'b1;
    load_pd(8'd3, 8'd2, "idle_load", 3'b001);
    step("idle_hold", 3'b001);
    en = 1'b1;
    step("enable", 3'b000);
    for (int k = 1; k <= 8; k++)
      step($sformatf("b2b_%0d", k), {((k - 1) % 4) < 2, (k % 4) == 0, 1'b0});

    // Restart with tick every 3rd clk: period 12 clk, levels held 3 clk each
    en = 1'b0; tick = 1'b0;
    step("stop_a", 3'b000);
    en = 1'b1;
    step("start_a", 3'b000);
    for (int k = 1; k <= 24; k++) begin
      tick = (k % 3) == 0;
      step($sformatf("slow_%0d", k), {((k - 1) % 12) < 6, (k % 12) == 0, 1'b0});
    end

    // Load P=7,D=6 at cnt=1: current period completes as 1,1,0,0
    tick = 1'b1;
    step("mid_a", 3'b100);
    load_pd(8'd7, 8'd6, "mid_load", 3'b101);
    step("mid_c", 3'b001);
    step("mid_wrap", 3'b010);
    for (int k = 1; k <= 16; k++)
      step($sformatf("p7d6_%0d", k), {((k - 1) % 8) < 6, (k % 8) == 0, 1'b0});

    // D=0 gives constant low
    load_pd(8'd7, 8'd0, "d0_load", 3'b101);
    for (int k = 1; k <= 5; k++) step($sformatf("d0_pend_%0d", k), 3'b101);
    step("d0_cnt6", 3'b001);
    step("d0_wrap", 3'b010);
    for (int k = 1; k <= 16; k++)
      step($sformatf("d0_%0d", k), {1'b0, (k % 8) == 0, 1'b0});

    // D=9 > P gives constant high
    load_pd(8'd7, 8'd9, "d9_load", 3'b001);
    for (int k = 1; k <= 6; k++) step($sformatf("d9_pend_%0d", k), 3'b001);
    step("d9_wrap", 3'b010);
    for (int k = 1; k <= 16; k++)
      step($sformatf("d9_%0d", k), {1'b1, (k % 8) == 0, 1'b0});

    // Back to P=3,D=2, then drop en at cnt=2
    load_pd(8'd3, 8'd2, "p3_load", 3'b101);
    for (int k = 1; k <= 6; k++) step($sformatf("p3_pend_%0d", k), 3'b101);
    step("p3_wrap", 3'b110);
    step("p3_c0", 3'b100);
    step("p3_c1", 3'b100);
    en = 1'b0;
    step("drop_en", 3'b000);
    step("idle_tick", 3'b000);
    en = 1'b1;
    step("reenable", 3'b000);
    step("re_0", 3'b100);
    step("re_1", 3'b100);
    step("re_2", 3'b000);
    step("re_3", 3'b010);
    step("re2_0", 3'b100);
    step("re2_1", 3'b100);
    step("re2_2", 3'b000);
    // Disable exactly at cnt==P with tick: no cycle_done
    en = 1'b0;
    step("drop_at_wrap", 3'b000);

    // Async reset mid-period with pending=1
    en = 1'b1;
    step("rs_enable", 3'b000);
    step("rs_c0", 3'b100);
    load_pd(8'd5, 8'd1, "rs_load", 3'b101);
    #2 rst = 1'b1;
    #1 chk("rst_mid", {pwm_out, cycle_done, pending}, 3'b000);
    step("rst_mid_hold", 3'b000);
    rst = 1'b0;
    step("post_rst_enable", 3'b000);
    for (int k = 1; k <= 4; k++) step($sformatf("p0_%0d", k), 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_tick_gen.md
PWM_TICK_GEN -- requirements
Module: pwm_tick_gen

Interface
REQ-001 Parameter: WIDTH, default 8, width of the counter, period and duty fields.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tick  input  1  single-cycle count-enable strobe from the upstream clock divider; synchronous to clk.
REQ-005 en  input  1  level; 1 = generator running, 0 = idle.
REQ-006 load  input  1  single-cycle strobe; captures period_in/duty_in into shadow registers.
REQ-007 period_in  input  WIDTH  period value P; period length is P+1 ticks.
REQ-008 duty_in  input  WIDTH  duty value D; high time is D ticks per period.
REQ-009 pwm_out  output  1  registered PWM waveform.
REQ-010 cycle_done  output  1  one-clk pulse at each period wrap.
REQ-011 pending  output  1  1 while shadow values await application.

Function
REQ-012 States SHALL be IDLE and RUN; IDLE->RUN when en=1; RUN->IDLE on the first clk edge with en=0, regardless of tick or counter position.
REQ-013 Counter cnt SHALL be WIDTH bits, advance only on clk edges with tick=1 in RUN, and hold otherwise.
REQ-014 In RUN with tick=1: if cnt==P_act, cnt SHALL become 0 and cycle_done SHALL be 1 for the next clk cycle; otherwise cnt SHALL become cnt+1 (no wrap beyond P_act).
REQ-015 cycle_done SHALL be 0 in every cycle other than the one following a wrap.
REQ-016 pwm_out SHALL be registered: in RUN, pwm_out = (cnt < D_act), evaluated on the current cnt and D_act, visible one clk later; in IDLE, pwm_out = 0.
REQ-017 D_act=0 SHALL give pwm_out constantly 0; D_act > P_act SHALL give pwm_out constantly 1 in RUN.
REQ-018 P_act=0 SHALL give a one-tick period: cycle_done after every tick, cnt remains 0.
REQ-019 load=1 SHALL copy period_in/duty_in into shadow registers and set pending=1 at the next edge; a second load before application SHALL overwrite the shadow values.
REQ-020 Shadow values SHALL be applied to P_act/D_act, and pending cleared, only at a period wrap (REQ-014) or on the IDLE->RUN transition; never mid-period.
REQ-021 If load and a wrap coincide in the same cycle, the wrap SHALL apply the previous shadow contents (if pending) and the new load SHALL set pending again for the following wrap.
REQ-022 If load occurs in IDLE, the values SHALL be applied at the next IDLE->RUN transition.
REQ-023 On IDLE->RUN, cnt SHALL be 0; the first period starts with cnt=0.
REQ-024 On RUN->IDLE, cnt SHALL be cleared to 0; shadow registers and pending SHALL be preserved.

Reset
REQ-025 While rst=1: state=IDLE, cnt=0, P_act=0, D_act=0, shadow registers=0, pending=0, pwm_out=0, cycle_done=0, regardless of clk.
REQ-026 After rst deasserts, the block SHALL start from IDLE on the first clk edge; a reset asserted mid-period SHALL abort the period with no trailing cycle_done.

Verification
REQ-027 load P=3,D=2 in IDLE, en=1, tick every clk -> pwm_out pattern 1,1,0,0 repeating (period 4 clk), cycle_done every 4th clk, pending 1->0 on enable.
REQ-028 Running P=3,D=2 with tick every 3rd clk -> each pwm level held 3 clk, period 12 clk, cycle_done single-clk wide.
REQ-029 Running P=3,D=2; load P=7,D=6 at cnt=1 -> current period completes as 1,1,0,0; following periods 6 high/2 low; pending=1 until that wrap.
REQ-030 D=0 then D=9 with P=7 -> pwm_out constantly 0, then constantly 1, cycle_done still every 8 ticks.
REQ-031 en dropped at cnt=2 of P=3 -> pwm_out 0 one clk later, cnt=0, no cycle_done; re-enable restarts at cnt=0 with same P/D.
REQ-032 rst asserted asynchronously mid-period with pending=1 -> all outputs 0 immediately, pending=0; after release with en=1 and no load, P_act=D_act=0 gives pwm_out=0 and cycle_done every tick.
